// File: rtl/pixel_scan_issuer.sv
// pixel_scan_issuer: raster-scan (x,y) issuer feeding the pixel-to-complex converter.
// Latches zoom/center once per frame, issues one coordinate per granted cycle and
// emits a tag stream delayed by the converter latency so tags line up with the
// converter outputs.
// Optional build macro: PIXEL_SCAN_FRAME_COUNT_EN adds a 16-bit completed-frame counter.

module pixel_scan_issuer #(
   parameter int SCREEN_WIDTH  = 960,
   parameter int SCREEN_HEIGHT = 720,
   parameter int WORD_LENGTH   = 32,
   parameter int CONV_LATENCY  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   issue_ready,
   input  logic [31:0]            zoom_in,
   input  logic [WORD_LENGTH-1:0] real_center_in,
   input  logic [WORD_LENGTH-1:0] imag_center_in,
   output logic [31:0]            zoom_out,
   output logic [WORD_LENGTH-1:0] real_center_out,
   output logic [WORD_LENGTH-1:0] imag_center_out,
   output logic [10:0]            x_out,
   output logic [10:0]            y_out,
   output logic                   tag_valid,
   output logic [10:0]            tag_x,
   output logic [10:0]            tag_y,
   output logic                   tag_sof,
   output logic                   tag_eol,
   output logic                   tag_eof,
   output logic                   busy,
   output logic                   frame_done
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
   ,
   output logic [15:0]            frame_count
`endif
);

   localparam logic [10:0] X_LAST = 11'(SCREEN_WIDTH - 1);
   localparam logic [10:0] Y_LAST = 11'(SCREEN_HEIGHT - 1);

   // Drain counter loads LATENCY-1 and counts down to zero.
   localparam int DCW = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY) : 1;
   localparam logic [DCW-1:0] DRAIN_INIT = DCW'(CONV_LATENCY - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StScan,
      StDrain
   } state_t;

   typedef struct packed {
      logic        valid;
      logic [10:0] x;
      logic [10:0] y;
      logic        sof;
      logic        eol;
      logic        eof;
   } tag_t;

   state_t         state;
   logic [10:0]    x_cnt;
   logic [10:0]    y_cnt;
   logic [DCW-1:0] drain_cnt;
   logic           issue;
   tag_t           tag_in;
   tag_t           tag_line [CONV_LATENCY];

   assign issue = (state == StScan) && issue_ready;

   // The counters are the coordinate outputs: they move only on the edge after an issue.
   assign x_out = x_cnt;
   assign y_out = y_cnt;
   assign busy  = (state != StIdle);

   // Frame sequencer: parameter latch, raster counters, drain timing and frame_done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= StIdle;
         x_cnt           <= '0;
         y_cnt           <= '0;
         drain_cnt       <= '0;
         zoom_out        <= '0;
         real_center_out <= '0;
         imag_center_out <= '0;
         frame_done      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (enable) begin
                  state <= StLoad;
               end
            end
            StLoad: begin
               zoom_out        <= zoom_in;
               real_center_out <= real_center_in;
               imag_center_out <= imag_center_in;
               x_cnt           <= '0;
               y_cnt           <= '0;
               state           <= StScan;
            end
            StScan: begin
               if (issue_ready) begin
                  if (x_cnt == X_LAST) begin
                     x_cnt <= '0;
                     if (y_cnt == Y_LAST) begin
                        y_cnt     <= '0;
                        drain_cnt <= DRAIN_INIT;
                        state     <= StDrain;
                        // With a one-deep converter the last tag surfaces in the only
                        // drain cycle, so the pulse must be armed here.
                        frame_done <= (CONV_LATENCY == 1);
                     end else begin
                        y_cnt <= y_cnt + 11'd1;
                     end
                  end else begin
                     x_cnt <= x_cnt + 11'd1;
                  end
               end
            end
            StDrain: begin
               if (drain_cnt == '0) begin
                  state <= enable ? StLoad : StIdle;
               end else begin
                  drain_cnt  <= drain_cnt - DCW'(1);
                  // Pulse lands in the final drain cycle, together with the eof tag.
                  frame_done <= (drain_cnt == DCW'(1));
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Tag entry for this cycle; bubbles are all-zero so the outputs read 0 when invalid.
   always_comb begin
      tag_in = '0;
      if (issue) begin
         tag_in.valid = 1'b1;
         tag_in.x     = x_cnt;
         tag_in.y     = y_cnt;
         tag_in.sof   = (x_cnt == '0) && (y_cnt == '0);
         tag_in.eol   = (x_cnt == X_LAST);
         tag_in.eof   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
      end
   end

   // Tag delay line: shifts every cycle, independent of issue_ready and FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CONV_LATENCY; i++) begin
            tag_line[i] <= '0;
         end
      end else begin
         tag_line[0] <= tag_in;
         for (int i = 1; i < CONV_LATENCY; i++) begin
            tag_line[i] <= tag_line[i-1];
         end
      end
   end

   assign tag_valid = tag_line[CONV_LATENCY-1].valid;
   assign tag_x     = tag_line[CONV_LATENCY-1].x;
   assign tag_y     = tag_line[CONV_LATENCY-1].y;
   assign tag_sof   = tag_line[CONV_LATENCY-1].sof;
   assign tag_eol   = tag_line[CONV_LATENCY-1].eol;
   assign tag_eof   = tag_line[CONV_LATENCY-1].eof;

`ifdef PIXEL_SCAN_FRAME_COUNT_EN
   // Completed-frame counter; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else if (frame_done) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_scan_issuer.sv
// Directed bench for pixel_scan_issuer with a 4x3 screen and a 2-cycle converter.
// A cycle-accurate vector table covers the first frame; tasks cover stalls,
// mid-frame parameter changes, enable drop, back-to-back frames and reset.

module tb_pixel_scan_issuer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int WL = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          issue_ready;
   logic [31:0]   zoom_in;
   logic [WL-1:0] real_center_in;
   logic [WL-1:0] imag_center_in;
   logic [31:0]   zoom_out;
   logic [WL-1:0] real_center_out;
   logic [WL-1:0] imag_center_out;
   logic [10:0]   x_out;
   logic [10:0]   y_out;
   logic          tag_valid;
   logic [10:0]   tag_x;
   logic [10:0]   tag_y;
   logic          tag_sof;
   logic          tag_eol;
   logic          tag_eof;
   logic          busy;
   logic          frame_done;
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
   logic [15:0]   frame_count;
`endif

   int tests  = 0;
   int failed = 0;

   pixel_scan_issuer #(
      .SCREEN_WIDTH  (W),
      .SCREEN_HEIGHT (H),
      .WORD_LENGTH   (WL),
      .CONV_LATENCY  (LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .issue_ready     (issue_ready),
      .zoom_in         (zoom_in),
      .real_center_in  (real_center_in),
      .imag_center_in  (imag_center_in),
      .zoom_out        (zoom_out),
      .real_center_out (real_center_out),
      .imag_center_out (imag_center_out),
      .x_out           (x_out),
      .y_out           (y_out),
      .tag_valid       (tag_valid),
      .tag_x           (tag_x),
      .tag_y           (tag_y),
      .tag_sof         (tag_sof),
      .tag_eol         (tag_eol),
      .tag_eof         (tag_eof),
      .busy            (busy),
      .frame_done      (frame_done)
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
      ,
      .frame_count     (frame_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rdy;
      logic        v;
      int          tx;
      int          ty;
      logic        sof;
      logic        eol;
      logic        eof;
      logic        fd;
      logic        bsy;
      int          xo;
      int          yo;
      logic [31:0] zo;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic en, input logic v, input int tx, input int ty,
                               input logic sof, input logic eol, input logic eof,
                               input logic fd, input logic bsy, input int xo, input int yo,
                               input logic [31:0] zo);
      vec_t r;
      r.en  = en;
      r.rdy = 1'b1;
      r.v   = v;
      r.tx  = tx;
      r.ty  = ty;
      r.sof = sof;
      r.eol = eol;
      r.eof = eof;
      r.fd  = fd;
      r.bsy = bsy;
      r.xo  = xo;
      r.yo  = yo;
      r.zo  = zo;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [81:0] pack_obs();
      return {tag_valid, tag_x, tag_y, tag_sof, tag_eol, tag_eof, frame_done, busy,
              x_out, y_out, zoom_out};
   endfunction

   // Runs until frame_done (bounded), checking tag order/flags, spacing and latched params.
   task automatic run_frame(input string nm, input bit toggle, input int drop_after,
                            input logic [31:0] exp_zoom, input logic [31:0] exp_real,
                            input bit poke);
      int  n         = 0;
      int  n_fd      = 0;
      int  err_order = 0;
      int  err_gap   = 0;
      int  err_param = 0;
      int  last_cyc  = 0;
      bit  done      = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         issue_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         #4;
         if (tag_valid) begin
            if ({tag_x, tag_y, tag_sof, tag_eol, tag_eof} !==
                {11'(n % W), 11'(n / W), n == 0, (n % W) == W - 1, n == W * H - 1})
               err_order++;
            if (toggle && n > 0 && cyc - last_cyc != 2) err_gap++;
            if (zoom_out !== exp_zoom || real_center_out !== exp_real) err_param++;
            last_cyc = cyc;
            n++;
            if (drop_after > 0 && n == drop_after) enable = 1'b0;
            if (poke && n == 2) begin
               zoom_in        = 32'd5;
               real_center_in = 32'h1234_5678;
            end
         end else if ({tag_x, tag_y, tag_sof, tag_eol, tag_eof} !== '0) begin
            err_order++;
         end
         if (frame_done) begin
            n_fd++;
            done = 1;
            if (n != W * H) err_order++;
         end
         tick();
      end
      check({nm, " tag count"}, 128'(n), 128'(W * H));
      check({nm, " tag order/flags"}, 128'(err_order), 128'd0);
      check({nm, " tag spacing"}, 128'(err_gap), 128'd0);
      check({nm, " latched params"}, 128'(err_param), 128'd0);
      check({nm, " frame_done pulses"}, 128'(n_fd), 128'd1);
   endtask

   initial begin
      int stray;
      rst            = 1'b1;
      enable         = 1'b0;
      issue_ready    = 1'b0;
      zoom_in        = 32'd3;
      real_center_in = 32'h0000_00AA;
      imag_center_in = 32'hFFFF_FF00;
      repeat (3) tick();
      #4;
      check("reset outputs", 128'(pack_obs()), 128'd0);
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
      check("reset frame_count", 128'(frame_count), 128'd0);
`endif
      tick();

      // First frame, cycle by cycle. LOAD at c1, issues c2..c13, tags c4..c15.
      //             en  v  tx ty sof eol eof fd bsy xo yo zo
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7);
      tbl[4]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 2, 0, 7);
      tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 7);
      tbl[6]  = mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 7);
      tbl[7]  = mk(0, 1, 3, 0, 0, 1, 0, 0, 1, 1, 1, 7);
      tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 1, 7);
      tbl[9]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 3, 1, 7);
      tbl[10] = mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 2, 7);
      tbl[11] = mk(0, 1, 3, 1, 0, 1, 0, 0, 1, 1, 2, 7);
      tbl[12] = mk(0, 1, 0, 2, 0, 0, 0, 0, 1, 2, 2, 7);
      tbl[13] = mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 3, 2, 7);
      tbl[14] = mk(0, 1, 2, 2, 0, 0, 0, 0, 1, 0, 0, 7);
      tbl[15] = mk(0, 1, 3, 2, 0, 1, 1, 1, 1, 0, 0, 7);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);

      rst     = 1'b0;
      zoom_in = 32'd7;
      for (int i = 0; i < 18; i++) begin
         logic [81:0] exp_v;
         enable      = tbl[i].en;
         issue_ready = tbl[i].rdy;
         exp_v = {tbl[i].v, 11'(tbl[i].tx), 11'(tbl[i].ty), tbl[i].sof, tbl[i].eol,
                  tbl[i].eof, tbl[i].fd, tbl[i].bsy, 11'(tbl[i].xo), 11'(tbl[i].yo),
                  tbl[i].zo};
         #4;
         check($sformatf("frame1 cycle %0d", i), 128'(pack_obs()), 128'(exp_v));
         tick();
      end
      #4;
      check("latched centers", 128'({real_center_out, imag_center_out}),
            128'({32'h0000_00AA, 32'hFFFF_FF00}));
      tick();

      // Stalls: ready alternates, tags two cycles apart, enable dropped after first tag.
      enable = 1'b1;
      run_frame("stall", 1'b1, 1, 32'd7, 32'h0000_00AA, 1'b0);

      // Enable dropped after third tag: frame still completes, then idle.
      enable = 1'b1;
      run_frame("enable drop", 1'b0, 3, 32'd7, 32'h0000_00AA, 1'b0);
      #4;
      check("idle after drop", 128'({busy, x_out, y_out}), 128'd0);
      tick();

      // Live inputs change mid-frame; three back-to-back frames with enable held.
      zoom_in = 32'd0;
      enable  = 1'b1;
      run_frame("params f1", 1'b0, 0, 32'd0, 32'h0000_00AA, 1'b1);
      #4;
      check("back-to-back f1", 128'(busy), 128'd1);
      tick();
      run_frame("params f2", 1'b0, 0, 32'd5, 32'h1234_5678, 1'b0);
      #4;
      check("back-to-back f2", 128'(busy), 128'd1);
      tick();
      run_frame("params f3", 1'b0, 1, 32'd5, 32'h1234_5678, 1'b0);
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
      #4;
      check("frame_count", 128'(frame_count), 128'd6);
      tick();
`endif

      // Reset in the middle of a scan with tags in flight.
      enable      = 1'b1;
      issue_ready = 1'b1;
      repeat (7) tick();
      #4;
      check("tags in flight before rst", 128'(tag_valid), 128'd1);
      rst    = 1'b1;
      enable = 1'b0;
      tick();
      #4;
      check("outputs after rst", 128'({pack_obs(), real_center_out}), 128'd0);
      tick();
      rst   = 1'b0;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         #4;
         if (tag_valid || frame_done || busy) stray++;
         tick();
      end
      check("no activity after rst", 128'(stray), 128'd0);
`ifdef PIXEL_SCAN_FRAME_COUNT_EN
      check("frame_count after rst", 128'(frame_count), 128'd0);
`endif
      enable = 1'b1;
      run_frame("restart", 1'b0, 1, 32'd5, 32'h1234_5678, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
